wb_stage: RTL and testbench

Writeback stage of the pipelined core. Accepts one retiring instruction per handshake from the memory stage, waits for data-memory read data on loads, and extracts, aligns and sign- or zero-extends it. It drives the register file write port (rd address, rd data, write enable) for exactly one cycle per retired instruction. It also exports the same write as a bypass source, because the register file has no internal write-to-read forwarding.

---
 rtl/wb_stage.sv | 109 ++++++++++
 tb/tb_wb_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per handshake, aligns/extends load data and drives the regfile write port and bypass.
// Optional retired-instruction counter o_instret is built when WB_INSTRET_EN is defined.
module wb_stage (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_rd_we,
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_alu_result,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_write_en,
`ifdef WB_INSTRET_EN
    output logic [63:0] o_instret,
`endif
    output logic        o_fwd_valid,
    output logic [4:0]  o_fwd_addr,
    output logic [31:0] o_fwd_data
);

    typedef enum logic {IDLE, WAIT_MEM} state_e;

    state_e      state;
    logic [4:0]  ld_rd_addr;
    logic        ld_rd_we;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;

    function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = 8'(rdata >> {addr_lo, 3'b000});
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  load_extract = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_extract = {24'd0, byte_sel};
            3'b001:  load_extract = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_extract = {16'd0, half_sel};
            default: load_extract = rdata;
        endcase
    endfunction

    assign o_ready     = (state == IDLE);
    assign o_fwd_valid = o_write_en;
    assign o_fwd_addr  = o_rd_addr;
    assign o_fwd_data  = o_rd_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_write_en <= 1'b0;
            o_rd_addr  <= 5'd0;
            o_rd_data  <= 32'd0;
            ld_rd_addr <= 5'd0;
            ld_rd_we   <= 1'b0;
            ld_funct3  <= 3'd0;
            ld_addr_lo <= 2'd0;
        end else begin
            o_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (i_is_load) begin
                            ld_rd_addr <= i_rd_addr;
                            ld_rd_we   <= i_rd_we;
                            ld_funct3  <= i_funct3;
                            ld_addr_lo <= i_addr_lo;
                            state      <= WAIT_MEM;
                        end else begin
                            o_rd_addr  <= i_rd_addr;
                            o_rd_data  <= i_alu_result;
                            o_write_en <= i_rd_we && (i_rd_addr != 5'd0);
                        end
                    end
                end
                WAIT_MEM: begin
                    if (i_dmem_rvalid) begin
                        o_rd_addr  <= ld_rd_addr;
                        o_rd_data  <= load_extract(ld_funct3, ld_addr_lo, i_dmem_rdata);
                        o_write_en <= ld_rd_we && (ld_rd_addr != 5'd0);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    // Counts completions, not writes: x0 targets and rd_we=0 still retire.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_instret <= 64'd0;
        end else if ((state == IDLE && i_valid && !i_is_load) ||
                     (state == WAIT_MEM && i_dmem_rvalid)) begin
            o_instret <= o_instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage; build with +define+WB_INSTRET_EN to also check the instret counter.
module tb_wb_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [4:0]  i_rd_addr = '0;
    logic        i_rd_we = 1'b0;
    logic        i_is_load = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [1:0]  i_addr_lo = '0;
    logic [31:0] i_alu_result = '0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_write_en;
    logic        o_fwd_valid;
    logic [4:0]  o_fwd_addr;
    logic [31:0] o_fwd_data;
`ifdef WB_INSTRET_EN
    logic [63:0] o_instret;
`endif

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    wb_stage dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_rd_addr     (i_rd_addr),
        .i_rd_we       (i_rd_we),
        .i_is_load     (i_is_load),
        .i_funct3      (i_funct3),
        .i_addr_lo     (i_addr_lo),
        .i_alu_result  (i_alu_result),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_write_en    (o_write_en),
`ifdef WB_INSTRET_EN
        .o_instret     (o_instret),
`endif
        .o_fwd_valid   (o_fwd_valid),
        .o_fwd_addr    (o_fwd_addr),
        .o_fwd_data    (o_fwd_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue_alu(input logic [4:0] rd, input logic we, input logic [31:0] res);
        i_valid = 1'b1; i_is_load = 1'b0; i_rd_addr = rd; i_rd_we = we; i_alu_result = res;
        step();
        i_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] rdata, input logic [31:0] exp);
        i_valid = 1'b1; i_is_load = 1'b1; i_rd_addr = rd; i_rd_we = 1'b1;
        i_funct3 = f3; i_addr_lo = lo;
        step();
        check({tag, "_ready_low"}, 64'(o_ready), 64'd0);
        check({tag, "_no_we"}, 64'(o_write_en), 64'd0);
        i_valid = 1'b0; i_is_load = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
        step();
        i_dmem_rvalid = 1'b0;
        check({tag, "_we"}, 64'(o_write_en), 64'd1);
        check({tag, "_addr"}, 64'(o_rd_addr), 64'(rd));
        check({tag, "_data"}, 64'(o_rd_data), 64'(exp));
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        // Reset state
        step(); step();
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_we", 64'(o_write_en), 64'd0);
        check("rst_addr", 64'(o_rd_addr), 64'd0);
        check("rst_data", 64'(o_rd_data), 64'd0);
        check("rst_fwd_valid", 64'(o_fwd_valid), 64'd0);
        i_rst_n = 1'b1;
        step();

        // Non-load write and bypass mirror
        issue_alu(5'd5, 1'b1, 32'h1234_5678);
        check("alu_we", 64'(o_write_en), 64'd1);
        check("alu_addr", 64'(o_rd_addr), 64'd5);
        check("alu_data", 64'(o_rd_data), 64'h1234_5678);
        check("alu_fwd_valid", 64'(o_fwd_valid), 64'd1);
        check("alu_fwd_addr", 64'(o_fwd_addr), 64'd5);
        check("alu_fwd_data", 64'(o_fwd_data), 64'h1234_5678);
        step();
        check("alu_we_single", 64'(o_write_en), 64'd0);
        check("alu_data_hold", 64'(o_rd_data), 64'h1234_5678);

        // rvalid in IDLE is ignored
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h5555_5555;
        step();
        i_dmem_rvalid = 1'b0;
        check("idle_rvalid_we", 64'(o_write_en), 64'd0);
        check("idle_rvalid_data", 64'(o_rd_data), 64'h1234_5678);

        // Load extraction table
        do_load("lb3",  5'd7,  3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lhu2", 5'd8,  3'b101, 2'd2, 32'h80FF_0000, 32'h0000_80FF);
        do_load("lh0",  5'd10, 3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001);
        do_load("lbu1", 5'd11, 3'b100, 2'd1, 32'h0000_F100, 32'h0000_00F1);
        do_load("lw",   5'd12, 3'b010, 2'd3, 32'hA1B2_C3D4, 32'hA1B2_C3D4);
        do_load("f3_011", 5'd13, 3'b011, 2'd1, 32'h0102_0304, 32'h0102_0304);

        // Load stalled three cycles with a non-load waiting on i_valid
        i_valid = 1'b1; i_is_load = 1'b1; i_rd_addr = 5'd9; i_rd_we = 1'b1;
        i_funct3 = 3'b010; i_addr_lo = 2'd0;
        step();
        check("stall_ready_0", 64'(o_ready), 64'd0);
        i_is_load = 1'b0; i_rd_addr = 5'd3; i_alu_result = 32'h0000_00AA;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", 64'(o_ready), 64'd0);
            check("stall_no_we", 64'(o_write_en), 64'd0);
        end
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
        step();
        i_dmem_rvalid = 1'b0;
        check("stall_ld_we", 64'(o_write_en), 64'd1);
        check("stall_ld_addr", 64'(o_rd_addr), 64'd9);
        check("stall_ld_data", 64'(o_rd_data), 64'hCAFE_F00D);
        check("stall_ld_ready", 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0;
        check("waiter_we", 64'(o_write_en), 64'd1);
        check("waiter_addr", 64'(o_rd_addr), 64'd3);
        check("waiter_data", 64'(o_rd_data), 64'h0000_00AA);

        // x0 destination
        issue_alu(5'd0, 1'b1, 32'hDEAD_BEEF);
        check("x0_we", 64'(o_write_en), 64'd0);
        check("x0_addr", 64'(o_rd_addr), 64'd0);
        check("x0_data", 64'(o_rd_data), 64'hDEAD_BEEF);

        // Reset during WAIT_MEM aborts the load
        i_valid = 1'b1; i_is_load = 1'b1; i_rd_addr = 5'd14; i_rd_we = 1'b1; i_funct3 = 3'b010;
        step();
        i_valid = 1'b0; i_is_load = 1'b0;
        check("abort_pre_ready", 64'(o_ready), 64'd0);
        i_rst_n = 1'b0;
        #1;
        check("abort_rst_ready", 64'(o_ready), 64'd1);
        check("abort_rst_data", 64'(o_rd_data), 64'd0);
        step();
        i_rst_n = 1'b1;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_2222;
        step();
        i_dmem_rvalid = 1'b0;
        check("abort_we", 64'(o_write_en), 64'd0);
        check("abort_ready", 64'(o_ready), 64'd1);
        check("abort_addr", 64'(o_rd_addr), 64'd0);
        check("abort_data", 64'(o_rd_data), 64'd0);
        check("abort_fwd_valid", 64'(o_fwd_valid), 64'd0);

        // Three back-to-back non-loads plus one load (rd_we=0 on one still retires)
        i_valid = 1'b1; i_is_load = 1'b0; i_rd_we = 1'b1;
        i_rd_addr = 5'd1; i_alu_result = 32'd1;
        step();
        check("b2b_1", 64'(o_rd_data), 64'd1);
        i_rd_addr = 5'd2; i_alu_result = 32'd2; i_rd_we = 1'b0;
        step();
        check("b2b_2_we", 64'(o_write_en), 64'd0);
        i_rd_addr = 5'd4; i_alu_result = 32'd3; i_rd_we = 1'b1;
        step();
        i_valid = 1'b0;
        check("b2b_3", 64'(o_rd_data), 64'd3);
        do_load("b2b_ld", 5'd6, 3'b010, 2'd0, 32'h0000_0044, 32'h0000_0044);
`ifdef WB_INSTRET_EN
        check("instret", o_instret, 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
